// File: rtl/lgn_result_scheduler.sv
// Streams per-class popcount scores and the argmax class of the network output to uart_tx,
// one byte in flight at a time.
module lgn_result_scheduler #(
    parameter int OUTPUT_BITS = 50,
    parameter int CLASSES     = 10,
    parameter int GROUP_BITS  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [OUTPUT_BITS-1:0] net_bits,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             argmax_idx,
    output logic                   argmax_valid
);

    localparam int BIW = $clog2(OUTPUT_BITS + 1);
    localparam int CIW = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam logic [BIW-1:0] LAST_BIT = BIW'(OUTPUT_BITS - 1);
    localparam logic [7:0]     LAST_GRP = 8'(GROUP_BITS - 1);
    localparam logic [7:0]     NCLS     = 8'(CLASSES);

    typedef enum logic [2:0] {IDLE, COUNT, LOAD, SEND, WAIT, FIN} state_t;
    state_t state, state_nx;

    logic [OUTPUT_BITS-1:0] bits_q;
    logic                   mode_q;
    logic [BIW-1:0]         bit_cnt;
    logic [7:0]             grp_cnt, cls_cnt, ptr;
    logic [7:0]             best_val, best_idx, best_val_nx, best_idx_nx;
    logic [7:0]             acc;
    logic [7:0]             score [CLASSES];

    // Bit-serial accumulate; a class competes for argmax only once its last bit is in.
    always_comb begin
        acc         = score[cls_cnt[CIW-1:0]] + {7'd0, bits_q[0]};
        best_val_nx = best_val;
        best_idx_nx = best_idx;
        if (grp_cnt == LAST_GRP && acc > best_val) begin
            best_val_nx = acc;
            best_idx_nx = cls_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_send  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = COUNT;
            COUNT: if (bit_cnt == LAST_BIT) state_nx = LOAD;
            LOAD:  state_nx = SEND;
            SEND: begin
                if (!tx_active) begin
                    tx_send  = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT:  if (tx_done) state_nx = (ptr == NCLS) ? FIN : LOAD;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q       <= '0;
            mode_q       <= 1'b0;
            bit_cnt      <= '0;
            grp_cnt      <= '0;
            cls_cnt      <= '0;
            ptr          <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            tx_data      <= '0;
            busy         <= 1'b0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
            for (int c = 0; c < CLASSES; c++) score[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bits_q       <= net_bits;
                        mode_q       <= mode;
                        bit_cnt      <= '0;
                        grp_cnt      <= '0;
                        cls_cnt      <= '0;
                        best_val     <= '0;
                        best_idx     <= '0;
                        argmax_valid <= 1'b0;
                        busy         <= 1'b1;
                        for (int c = 0; c < CLASSES; c++) score[c] <= '0;
                    end
                end
                COUNT: begin
                    bits_q                   <= bits_q >> 1;
                    score[cls_cnt[CIW-1:0]]  <= acc;
                    bit_cnt                  <= bit_cnt + 1'b1;
                    best_val                 <= best_val_nx;
                    best_idx                 <= best_idx_nx;
                    if (grp_cnt == LAST_GRP) begin
                        grp_cnt <= '0;
                        cls_cnt <= cls_cnt + 8'd1;
                    end else begin
                        grp_cnt <= grp_cnt + 8'd1;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        argmax_idx   <= best_idx_nx;
                        argmax_valid <= 1'b1;
                        ptr          <= mode_q ? NCLS : 8'd0;
                        cls_cnt      <= '0;
                    end
                end
                LOAD: tx_data <= (ptr < NCLS) ? score[ptr[CIW-1:0]] : argmax_idx;
                WAIT: if (tx_done && ptr != NCLS) ptr <= ptr + 8'd1;
                FIN:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_result_scheduler.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops them on each tx_send.
module tb_lgn_result_scheduler;

    localparam int OB = 50;
    localparam int NC = 10;
    localparam int GB = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [OB-1:0] net_bits = '0;
    logic          tx_active;
    logic          tx_done = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          busy;
    logic          done;
    logic [7:0]    argmax_idx;
    logic          argmax_valid;

    logic model_active = 1'b0;
    logic hold_active  = 1'b0;
    assign tx_active = model_active | hold_active;

    lgn_result_scheduler #(.OUTPUT_BITS(OB), .CLASSES(NC), .GROUP_BITS(GB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .net_bits(net_bits),
        .tx_active(tx_active), .tx_done(tx_done), .tx_data(tx_data), .tx_send(tx_send),
        .busy(busy), .done(done), .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int send_cnt = 0, done_cnt = 0, cyc_n = 0, send_cyc = 0, start_at = 0;
    bit lat_arm = 0, inflight = 0, prev_send = 0;
    logic [7:0] sent_byte, e_byte;
    logic [7:0] t2 [11] = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            inflight  = 0;
            prev_send = 0;
        end else begin
            if (tx_send) begin
                chk("send_one_cycle", 32'(prev_send), 0);
                send_cnt++;
                if (lat_arm) begin
                    send_cyc = cyc_n;
                    lat_arm  = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(exp_q.size()), 1);
                end else begin
                    e_byte = exp_q.pop_front();
                    chk("byte", 32'(tx_data), 32'(e_byte));
                end
                sent_byte = tx_data;
                inflight  = 1;
            end
            if (tx_done && inflight) begin
                chk("data_stable", 32'(tx_data), 32'(sent_byte));
                inflight = 0;
            end
            if (done) done_cnt++;
            prev_send = tx_send;
        end
    end

    // uart_tx model: busy for a few cycles after each byte, then a Done pulse
    initial forever begin
        @(negedge clk);
        if (tx_send && rst_n) begin
            @(posedge clk); #1 model_active = 1'b1;
            repeat (3) @(posedge clk);
            #1 model_active = 1'b0; tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
        end
    end

    task automatic start_frame(input logic [OB-1:0] b, input logic m);
        @(posedge clk); #1 net_bits = b; mode = m; start = 1'b1;
        start_at = cyc_n + 1;
        @(posedge clk); #1 start = 1'b0; net_bits = ~b; mode = ~m;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        chk("argmax_valid_cleared", 32'(argmax_valid), 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            @(negedge clk);
            chk({name, "_done_width"}, 32'(done), 0);
            chk({name, "_busy_clear"}, 32'(busy), 0);
        end
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 0);
        chk({name, "_argmax_valid"}, 32'(argmax_valid), 1);
    endtask

    initial begin
        logic [OB-1:0] b;
        int c0, d0;
        bit hit;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_argmax_idx", 32'(argmax_idx), 0);
        chk("rst_argmax_valid", 32'(argmax_valid), 0);
        rst_n = 1'b1;

        // all-zero input, full frame, first-byte latency
        for (int i = 0; i < 11; i++) exp_q.push_back(8'd0);
        lat_arm = 1;
        start_frame('0, 1'b0);
        wait_done("t1", 400);
        chk("t1_argmax", 32'(argmax_idx), 0);
        chk("t1_latency", 32'(send_cyc - start_at), 52);
        chk("t1_done_count", 32'(done_cnt), 1);

        // class3 = 5, class7 = 3
        b = '0; b[15 +: 5] = 5'b11111; b[35 +: 5] = 5'b01011;
        foreach (t2[i]) exp_q.push_back(t2[i]);
        start_frame(b, 1'b0);
        wait_done("t2", 400);
        chk("t2_argmax", 32'(argmax_idx), 3);

        // tie between class2 and class6, argmax only
        b = '0; b[10 +: 5] = 5'b00111; b[30 +: 5] = 5'b00111;
        exp_q.push_back(8'd2);
        start_frame(b, 1'b1);
        wait_done("t3", 200);
        chk("t3_argmax", 32'(argmax_idx), 2);

        // uart held busy at SEND; mid-frame start ignored
        b = '0; b[45 +: 5] = 5'b10000;
        for (int i = 0; i < 9; i++) exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd9);
        hold_active = 1'b1;
        c0 = send_cnt;
        start_frame(b, 1'b0);
        repeat (20) @(posedge clk);
        #1 start = 1'b1; net_bits = '1; mode = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk("t4_no_send_while_active", 32'(send_cnt), 32'(c0));
        chk("t4_busy_held", 32'(busy), 1);
        hold_active = 1'b0;
        wait_done("t4", 400);
        chk("t4_argmax", 32'(argmax_idx), 9);
        chk("t4_done_count", 32'(done_cnt), 4);

        // reset during the 4th byte's WAIT
        for (int i = 0; i < 4; i++) exp_q.push_back(t2[i]);
        b = '0; b[15 +: 5] = 5'b11111; b[35 +: 5] = 5'b01011;
        c0 = send_cnt;
        d0 = done_cnt;
        start_frame(b, 1'b0);
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk); #2;
            if (send_cnt == c0 + 4) hit = 1;
        end
        chk("t5_reached_4th_byte", 32'(hit), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_data", 32'(tx_data), 0);
        chk("t5_rst_tx_send", 32'(tx_send), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_argmax_idx", 32'(argmax_idx), 0);
        chk("t5_rst_argmax_valid", 32'(argmax_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_done_after_reset", 32'(done_cnt), 32'(d0));
        chk("t5_queue_consumed", 32'(exp_q.size()), 0);
        foreach (t2[i]) exp_q.push_back(t2[i]);
        start_frame(b, 1'b0);
        wait_done("t5b", 400);
        chk("t5b_argmax", 32'(argmax_idx), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
